arb8_sel138: RTL

- 8-way round-robin arbiter/sequencer for a shared resource selected through a 3-to-8 decoder (LS138-class).
- Samples active-low requests and drives the decoder select code (c,b,a) and its three enables (g1, g2a_, g2b_).
- Also provides an equivalent active-low one-hot grant vector, so benches can check it against a decoder model.
- Sits between requesting boards/devices and the decoder that gates their bus drivers.
- Guarantees break-before-make between successive owners.

---
 rtl/arb8_sel138.sv | 84 ++++++++
 1 files changed

// File: rtl/arb8_sel138.sv
// arb8_sel138: 8-way round-robin arbiter driving a 3-to-8 decoder select/enable set plus a one-hot active-low grant.
module arb8_sel138 #(
  parameter int HOLD_MIN = 1,
  parameter int TIMEOUT = 0,
  parameter int tCO = 0
) (
  input  logic       clk,
  input  logic       clr_,
  input  logic       en_,
  input  logic [7:0] req_,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       g1,
  output logic       g2a_,
  output logic       g2b_,
  output logic [7:0] gnt_,
  output logic       busy,
  output logic       to
);
  typedef enum logic {IDLE, GRANT} state_t;
  // tCO is a simulation-only output delay, so it contributes nothing to the hold threshold.
  localparam int HOLD = ((HOLD_MIN < 1) ? 1 : HOLD_MIN) + 0 * tCO;
  state_t     state_q, state_d;
  logic [2:0] last_q, last_d, sel_q, sel_d, pick;
  logic [7:0] cnt_q, cnt_d, gnt_q, gnt_d, r;
  logic [8:0] n;
  logic       to_q, to_d, tmo, rel;
  always_comb begin
    r = ~req_;
    pick = last_q;
    // Scan downward so the nearest requester after last overrides farther ones; last itself is scanned first.
    for (int i = 8; i >= 1; i--)
      if (r[last_q + 3'(i)]) pick = last_q + 3'(i);
    n = {1'b0, cnt_q} + 9'd1;
    tmo = (TIMEOUT != 0) && (n == 9'(TIMEOUT));
    rel = (n >= 9'(HOLD)) && req_[sel_q];
    state_d = state_q;
    last_d = last_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    gnt_d = gnt_q;
    to_d = 1'b0;
    if (state_q == IDLE) begin
      if (!en_ && |r) begin
        state_d = GRANT;
        sel_d = pick;
        gnt_d = ~(8'd1 << pick);
        cnt_d = 8'd0;
      end
    end else if (tmo || rel) begin
      state_d = IDLE;
      last_d = sel_q;
      gnt_d = 8'hFF;
      to_d = tmo;
    end else begin
      cnt_d = &cnt_q ? cnt_q : cnt_q + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      state_q <= IDLE;
      last_q <= 3'd7;
      sel_q <= 3'd0;
      cnt_q <= 8'd0;
      gnt_q <= 8'hFF;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      to_q <= to_d;
    end
  end
  assign {c, b, a} = sel_q;
  assign busy = (state_q == GRANT);
  assign g1 = busy;
  assign g2a_ = ~busy;
  assign g2b_ = ~busy;
  assign gnt_ = gnt_q;
  assign to = to_q;
endmodule
